// File: rtl/pio_pkg.sv
// Shared constants for the GPIO port: register word offsets and edge-capture modes.
package pio_pkg;
  localparam logic [2:0] PIO_DATA    = 3'd0;
  localparam logic [2:0] PIO_DIR     = 3'd1;
  localparam logic [2:0] PIO_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_gpio_irq_if.sv
// Avalon-MM slave bus bundle for the GPIO port (readLatency 1, active-low strobes).
interface pio_gpio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/pio_sync_edge.sv
// Pin synchroniser plus previous-sample flop; emits a one-cycle pulse per bit on the selected edge.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev_q;
  assign fall    = ~in_sync & prev_q;

  if (EDGE_TYPE == EDGE_RISE) begin : g_rise
    assign edge_pulse = rise;
  end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign edge_pulse = fall;
  end else begin : g_any
    assign edge_pulse = rise | fall;
  end
endmodule

// File: rtl/pio_gpio_irq.sv
// Avalon-MM GPIO port: per-bit direction, atomic set/clear, edge capture with W1C and maskable level irq.
module pio_gpio_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_gpio_irq_if.slave    bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_pulse;
  logic [31:0]      rd_val;

  // Bits of writedata above WIDTH are deliberately ignored.
  wire unused_wd = &{1'b0, bus.writedata};

  assign wr       = bus.chipselect & ~bus.write_n;
  assign rd       = bus.chipselect & ~bus.read_n;
  assign wd       = bus.writedata[WIDTH-1:0];
  assign w1c_mask = (wr && bus.address == PIO_EDGECAP) ? wd : '0;
  assign out_port = data_out;
  assign oe       = dir;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .in_sync   (in_sync),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    rd_val = '0;
    case (bus.address)
      PIO_DATA:    rd_val = 32'((dir & data_out) | (~dir & in_sync));
      PIO_DIR:     rd_val = 32'(dir);
      PIO_IRQMASK: rd_val = 32'(mask);
      PIO_EDGECAP: rd_val = 32'(edgecap);
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out     <= RESET_VALUE;
      dir          <= DIR_RESET;
      mask         <= '0;
      edgecap      <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr) begin
        case (bus.address)
          PIO_DATA:    data_out <= wd;
          PIO_DIR:     dir      <= wd;
          PIO_IRQMASK: mask     <= wd;
          PIO_OUTSET:  data_out <= data_out | wd;
          PIO_OUTCLR:  data_out <= data_out & ~wd;
          default:     ;
        endcase
      end
      // A fresh edge outranks a same-cycle clear so no event is lost.
      edgecap <= (edgecap & ~w1c_mask) | edge_pulse;
      if (rd) bus.readdata <= rd_val;
      irq <= |(edgecap & mask);
    end
  end
endmodule

// File: tb/tb_pio_gpio_irq.sv
// Bench for pio_gpio_irq: rising-edge and any-edge instances driven in lockstep, reads scored via queue.
module tb_pio_gpio_irq;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [7:0]  out0, oe0, out1, oe1;
  logic        irq0, irq1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pio_gpio_irq_if bus0 ();
  pio_gpio_irq_if bus1 ();

  assign bus0.address    = address;
  assign bus0.chipselect = chipselect;
  assign bus0.write_n    = write_n;
  assign bus0.read_n     = read_n;
  assign bus0.writedata  = writedata;
  assign bus1.address    = address;
  assign bus1.chipselect = chipselect;
  assign bus1.write_n    = write_n;
  assign bus1.read_n     = read_n;
  assign bus1.writedata  = writedata;

  pio_gpio_irq #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hF0), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port),
    .out_port(out0), .oe(oe0), .irq(irq0)
  );

  pio_gpio_irq #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hF0), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port),
    .out_port(out1), .oe(oe1), .irq(irq1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Read scoreboard: one entry per issued read, expected data for both instances.
  typedef struct {
    logic [31:0] exp0;
    logic [31:0] exp1;
    string       name;
  } rd_exp_t;
  rd_exp_t sb_q[$];
  logic    rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= reset_n && chipselect && !read_n;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got read with no expectation");
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_rise"}, bus0.readdata, e.exp0);
        chk({e.name, "_any"}, bus1.readdata, e.exp1);
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e1, input string name);
    rd_exp_t e;
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    e.exp0 = e0; e.exp1 = e1; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e0, input string name);
    rd_exp_t e;
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
    e.exp0 = e0; e.exp1 = e0; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic [7:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  typedef struct {
    logic        is_rd;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;
  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, PIO_DATA,    32'h3C, 8'h3C, 8'hF0, 32'h0,  "wr_data"};
    vecs[1]  = '{1'b0, PIO_OUTSET,  32'h01, 8'h3D, 8'hF0, 32'h0,  "wr_outset"};
    vecs[2]  = '{1'b0, PIO_OUTCLR,  32'h0C, 8'h31, 8'hF0, 32'h0,  "wr_outclr"};
    vecs[3]  = '{1'b0, PIO_DIR,     32'hFF, 8'h31, 8'hFF, 32'h0,  "wr_dir"};
    vecs[4]  = '{1'b0, 3'd6,        32'hFF, 8'h31, 8'hFF, 32'h0,  "wr_rsv6"};
    vecs[5]  = '{1'b0, 3'd7,        32'hFF, 8'h31, 8'hFF, 32'h0,  "wr_rsv7"};
    vecs[6]  = '{1'b0, PIO_IRQMASK, 32'h04, 8'h31, 8'hFF, 32'h0,  "wr_mask"};
    vecs[7]  = '{1'b1, PIO_DATA,    32'h0,  8'h31, 8'hFF, 32'h31, "rd_data"};
    vecs[8]  = '{1'b1, PIO_DIR,     32'h0,  8'h31, 8'hFF, 32'hFF, "rd_dir"};
    vecs[9]  = '{1'b1, PIO_IRQMASK, 32'h0,  8'h31, 8'hFF, 32'h04, "rd_mask"};
    vecs[10] = '{1'b1, PIO_OUTSET,  32'h0,  8'h31, 8'hFF, 32'h0,  "rd_outset"};
    vecs[11] = '{1'b1, PIO_OUTCLR,  32'h0,  8'h31, 8'hFF, 32'h0,  "rd_outclr"};
    vecs[12] = '{1'b1, 3'd6,        32'h0,  8'h31, 8'hFF, 32'h0,  "rd_rsv6"};
    vecs[13] = '{1'b1, PIO_EDGECAP, 32'h0,  8'h31, 8'hFF, 32'h0,  "rd_edgecap0"};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = '0; writedata = '0; in_port = '0;

    // Reset state
    idle(3);
    chk("rst_out", 32'(out0), 32'hA5);
    chk("rst_oe", 32'(oe0), 32'hF0);
    chk("rst_irq", 32'({irq1, irq0}), 32'h0);
    chk("rst_rdata", bus0.readdata | bus1.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Register table: writes check pins, reads go through the scoreboard
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_rd) rd(vecs[i].addr, vecs[i].exp_rd, vecs[i].exp_rd, vecs[i].name);
      else wr(vecs[i].addr, vecs[i].wd);
      chk({vecs[i].name, "_out"}, 32'(out0), 32'(vecs[i].exp_out));
      chk({vecs[i].name, "_oe"}, 32'(oe0), 32'(vecs[i].exp_oe));
    end
    chk("tbl_out_any", 32'(out1), 32'h31);

    // Read and write to the same register in one cycle return the old value
    rdwr(PIO_DATA, 32'h55, 32'h31, "rdwr_data");
    chk("rdwr_out", 32'(out0), 32'h55);

    // Rising edge on bit 2 reaches edgecap after SYNC_STAGES+1 edges, irq one edge later
    wr(PIO_DIR, 32'h00);
    chk("dir0_oe", 32'(oe0), 32'h00);
    set_pins(8'h04);
    @(posedge clk);
    rd(PIO_EDGECAP, 32'h0, 32'h0, "ecap_e2");
    rd(PIO_EDGECAP, 32'h0, 32'h0, "ecap_e3");
    chk("irq_e3", 32'({irq1, irq0}), 32'h0);
    rd(PIO_EDGECAP, 32'h04, 32'h04, "ecap_e4");
    chk("irq_e4", 32'({irq1, irq0}), 32'h3);
    rd(PIO_DATA, 32'h04, 32'h04, "rd_in_sync");

    // Clear coinciding with a new rising edge on the same bit: the edge wins
    set_pins(8'h00);
    idle(6);
    set_pins(8'h04);
    @(posedge clk);
    @(posedge clk);
    wr(PIO_EDGECAP, 32'h04);
    chk("w1c_race_irq", 32'({irq1, irq0}), 32'h3);
    idle(1);
    chk("w1c_race_irq2", 32'({irq1, irq0}), 32'h3);
    rd(PIO_EDGECAP, 32'h04, 32'h04, "w1c_race_ecap");
    wr(PIO_EDGECAP, 32'h04);
    chk("w1c_irq_hold", 32'({irq1, irq0}), 32'h3);
    idle(1);
    chk("w1c_irq_drop", 32'({irq1, irq0}), 32'h0);
    rd(PIO_EDGECAP, 32'h0, 32'h0, "w1c_ecap");

    // Falling edge only: captured by the any-edge instance alone
    wr(PIO_IRQMASK, 32'h00);
    set_pins(8'h84);
    idle(6);
    wr(PIO_EDGECAP, 32'hFF);
    set_pins(8'h04);
    idle(6);
    rd(PIO_EDGECAP, 32'h00, 32'h80, "fall_ecap");
    wr(PIO_EDGECAP, 32'hFF);

    // Double toggle on bit 7 with mask off, then unmask
    set_pins(8'h84);
    idle(4);
    set_pins(8'h04);
    idle(6);
    rd(PIO_EDGECAP, 32'h80, 32'h80, "tog_ecap");
    chk("tog_irq_masked", 32'({irq1, irq0}), 32'h0);
    wr(PIO_IRQMASK, 32'h80);
    chk("tog_irq_mask_edge", 32'({irq1, irq0}), 32'h0);
    idle(1);
    chk("tog_irq_unmasked", 32'({irq1, irq0}), 32'h3);

    // Fill edgecap, then reset in the middle of a DATA write
    set_pins(8'hFB);
    idle(6);
    wr(PIO_IRQMASK, 32'hFF);
    rd(PIO_EDGECAP, 32'hFB, 32'hFF, "full_ecap");
    chk("full_irq", 32'({irq1, irq0}), 32'h3);
    @(negedge clk);
    address = PIO_DATA; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
    reset_n = 1'b0; in_port = 8'h00;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    chk("midrst_out", 32'({out1, out0}), 32'hA5A5);
    chk("midrst_oe", 32'({oe1, oe0}), 32'hF0F0);
    chk("midrst_irq", 32'({irq1, irq0}), 32'h0);
    chk("midrst_rdata", bus0.readdata | bus1.readdata, 32'h0);
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    rd(PIO_EDGECAP, 32'h0, 32'h0, "post_rst_ecap");
    rd(PIO_IRQMASK, 32'h0, 32'h0, "post_rst_mask");
    rd(PIO_DIR, 32'hF0, 32'hF0, "post_rst_dir");
    rd(PIO_DATA, 32'hA0, 32'hA0, "post_rst_data");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending reads expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
